// File: rtl/tx_burst_array_pkg.sv
// Shared command encodings and channel state for the transducer burst array.
// Package tx_pkg is imported by the channel and the top.
package tx_pkg;

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_FIRE  = 2'b10;
  localparam logic [1:0] CMD_RESET = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_PULSE,
    ST_DONE,
    ST_FAULT
  } chan_state_e;

endpackage

// File: rtl/tx_burst_array_if.sv
// Control/status bundle of the transducer burst array.
// master drives commands and config, slave drives the per-channel status.
interface tx_burst_array_if #(
  parameter int NCH     = 8,
  parameter int PD_W    = 16,
  parameter int CT_W    = 9,
  parameter int BURST_W = 4
);

  logic [31:0]          cntr;
  logic [1:0]           cmd;
  logic [NCH*PD_W-1:0]  phaseDelay;
  logic [NCH*PD_W-1:0]  fireAtPhaseDelay;
  logic                 fireSwitch;
  logic [NCH*CT_W-1:0]  chargeTime;
  logic [NCH-1:0]       chanEnable;
  logic [BURST_W-1:0]   pulseCount;
  logic [15:0]          pulsePeriod;
  logic [NCH-1:0]       txOutputState;
  logic [NCH-1:0]       isActive;
  logic [NCH-1:0]       errorFlag;
  logic                 burstDone;

  modport master (
    output cntr, cmd, phaseDelay, fireAtPhaseDelay, fireSwitch,
    output chargeTime, chanEnable, pulseCount, pulsePeriod,
    input  txOutputState, isActive, errorFlag, burstDone
  );

  modport slave (
    input  cntr, cmd, phaseDelay, fireAtPhaseDelay, fireSwitch,
    input  chargeTime, chanEnable, pulseCount, pulsePeriod,
    output txOutputState, isActive, errorFlag, burstDone
  );

endinterface

// File: rtl/tx_burst_array_channel.sv
// One transducer channel: delayed, repeated pulse burst against cntr.
// Optional stuck-high timeout guarded by macro TX_SAFETY_VALVE_EN.
module tx_channel
  import tx_pkg::*;
#(
  parameter int PD_W    = 16,
  parameter int CT_W    = 9,
  parameter int BURST_W = 4,
  parameter int SAFE_W  = 10
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [31:0]        cntr,
  input  logic [1:0]         cmd,
  input  logic [PD_W-1:0]    primary_delay,
  input  logic [PD_W-1:0]    alt_delay,
  input  logic               fire_switch,
  input  logic [CT_W-1:0]    charge_time,
  input  logic               enable,
  input  logic [BURST_W-1:0] pulse_count,
  input  logic [15:0]        pulse_period,
  output logic               tx,
  output logic               active,
  output logic               error,
  output logic               fin
);

  chan_state_e        state_q, state_d;
  logic               tx_q, tx_d;
  logic               act_q, act_d;
  logic               err_q, err_d;
  logic [31:0]        start_q, start_d;
  logic [CT_W-1:0]    ct_q, ct_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic [15:0]        per_q, per_d;
  logic [PD_W-1:0]    dly;
  logic [31:0]        end_pt;

  assign dly    = fire_switch ? primary_delay : alt_delay;
  assign end_pt = start_q + 32'(ct_q);

`ifdef TX_SAFETY_VALVE_EN
  logic [SAFE_W-1:0] safe_q;
  logic [SAFE_W-1:0] safe_inc;

  assign safe_inc = safe_q + SAFE_W'(1);

  // high-time counter, cleared whenever the drive is low
  always_ff @(posedge clk) begin
    if (!reset_n) safe_q <= '0;
    else          safe_q <= tx_q ? safe_inc : '0;
  end
`endif

  // state and latched burst parameters
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      tx_q    <= 1'b0;
      act_q   <= 1'b0;
      err_q   <= 1'b0;
      start_q <= '0;
      ct_q    <= '0;
      rem_q   <= '0;
      per_q   <= '0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      act_q   <= act_d;
      err_q   <= err_d;
      start_q <= start_d;
      ct_q    <= ct_d;
      rem_q   <= rem_d;
      per_q   <= per_d;
    end
  end

  // command decode and burst sequencing
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    act_d   = act_q;
    err_d   = err_q;
    start_d = start_q;
    ct_d    = ct_q;
    rem_d   = rem_q;
    per_d   = per_q;
    unique case (1'b1)
      cmd == CMD_FIRE: begin
        case (state_q)
          ST_IDLE: begin
            start_d = 32'(dly);
            ct_d    = charge_time;
            rem_d   = pulse_count;
            per_d   = pulse_period;
            if (!enable || charge_time == '0 ||
                pulse_count == '0) begin
              state_d = ST_DONE;
            end else if (pulse_count > BURST_W'(1) &&
                         32'(pulse_period) <=
                         32'(charge_time)) begin
              state_d = ST_DONE;
              err_d   = 1'b1;
            end else begin
              act_d = 1'b1;
              if (dly == '0) begin
                state_d = ST_PULSE;
                tx_d    = 1'b1;
              end else begin
                state_d = ST_WAIT;
              end
            end
          end
          ST_WAIT: begin
            if (cntr >= start_q) begin
              state_d = ST_PULSE;
              tx_d    = 1'b1;
            end
          end
          ST_PULSE: begin
            if (cntr >= end_pt) begin
              tx_d  = 1'b0;
              rem_d = rem_q - BURST_W'(1);
              if (rem_q == BURST_W'(1)) begin
                state_d = ST_DONE;
                act_d   = 1'b0;
              end else begin
                start_d = start_q + 32'(per_q);
                state_d = ST_WAIT;
              end
            end
          end
          default: begin
            tx_d = 1'b0;
          end
        endcase
`ifdef TX_SAFETY_VALVE_EN
        if (tx_q && safe_inc[SAFE_W-1]) begin
          state_d = ST_FAULT;
          tx_d    = 1'b0;
          act_d   = 1'b0;
          err_d   = 1'b1;
        end
`endif
      end
      cmd == CMD_IDLE: begin
        state_d = ST_IDLE;
        tx_d    = 1'b0;
        act_d   = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b0;
        act_d   = 1'b0;
        err_d   = 1'b0;
      end
    endcase
  end

  assign tx     = tx_q;
  assign active = act_q;
  assign error  = err_q;
  assign fin    = (state_q == ST_DONE) ||
                  (state_q == ST_FAULT);

endmodule

// File: rtl/tx_burst_array.sv
// Transducer burst array: NCH tx_channel instances plus burstDone.
// Define TX_SAFETY_VALVE_EN to enable the per-channel stuck-high timeout.
module tx_burst_array
  import tx_pkg::*;
#(
  parameter int NCH     = 8,
  parameter int PD_W    = 16,
  parameter int CT_W    = 9,
  parameter int BURST_W = 4,
  parameter int SAFE_W  = 10
) (
  input logic             clk,
  input logic             reset_n,
  tx_burst_array_if.slave bus
);

  logic [NCH-1:0] tx_v;
  logic [NCH-1:0] act_v;
  logic [NCH-1:0] err_v;
  logic [NCH-1:0] fin_v;
  logic           done_q;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    tx_channel #(
      .PD_W    (PD_W),
      .CT_W    (CT_W),
      .BURST_W (BURST_W),
      .SAFE_W  (SAFE_W)
    ) u_ch (
      .clk           (clk),
      .reset_n       (reset_n),
      .cntr          (bus.cntr),
      .cmd           (bus.cmd),
      .primary_delay (bus.phaseDelay[i*PD_W +: PD_W]),
      .alt_delay     (bus.fireAtPhaseDelay[i*PD_W +: PD_W]),
      .fire_switch   (bus.fireSwitch),
      .charge_time   (bus.chargeTime[i*CT_W +: CT_W]),
      .enable        (bus.chanEnable[i]),
      .pulse_count   (bus.pulseCount),
      .pulse_period  (bus.pulsePeriod),
      .tx            (tx_v[i]),
      .active        (act_v[i]),
      .error         (err_v[i]),
      .fin           (fin_v[i])
    );
  end

  // disabled channels park in DONE, so all-finished covers the enabled set
  always_ff @(posedge clk) begin
    if (!reset_n) done_q <= 1'b0;
    else          done_q <= (bus.cmd == CMD_FIRE) && (&fin_v);
  end

  assign bus.txOutputState = tx_v;
  assign bus.isActive      = act_v;
  assign bus.errorFlag     = err_v;
  assign bus.burstDone     = done_q;

endmodule

// File: tb/tb_tx_burst_array.sv
// Scoreboard bench for tx_burst_array with four channels.
// Stimulus queues expected outputs per clock edge; a monitor compares.
module tb_tx_burst_array;
  import tx_pkg::*;

  typedef struct {
    int         ed;
    logic [3:0] tx;
    logic [3:0] act;
    logic [3:0] err;
    logic       bd;
    string      tag;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  int   ecnt = 0;
  int   passed = 0;
  int   total = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  tx_burst_array_if #(.NCH(4)) bus();

  tx_burst_array #(.NCH(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  function automatic void exp_at(int ed, logic [3:0] tx,
                                 logic [3:0] act, logic [3:0] err,
                                 logic bd, string tag);
    exp_t x;
    x.ed  = ed;
    x.tx  = tx;
    x.act = act;
    x.err = err;
    x.bd  = bd;
    x.tag = tag;
    q.push_back(x);
  endfunction

  // monitor: edge counter and scoreboard pop
  initial begin
    exp_t x;
    logic [12:0] got, want;
    forever begin
      @(posedge clk);
      #1;
      ecnt++;
      while (q.size() > 0 && q[0].ed <= ecnt) begin
        x = q.pop_front();
        total++;
        got  = {bus.txOutputState, bus.isActive,
                bus.errorFlag, bus.burstDone};
        want = {x.tx, x.act, x.err, x.bd};
        if (x.ed != ecnt) begin
          $display("FAIL %s edge %0d missed at edge %0d",
                   x.tag, x.ed, ecnt);
        end else if (got !== want) begin
          $display("FAIL %s edge %0d tx/act/err/bd got %b %b %b %b want %b %b %b %b",
                   x.tag, x.ed, got[12:9], got[8:5], got[4:1], got[0],
                   want[12:9], want[8:5], want[4:1], want[0]);
        end else begin
          passed++;
        end
      end
    end
  end

  // starts a burst with cntr=0 at the latch edge; returns that edge
  task automatic fire_start(output int p0);
    @(negedge clk);
    bus.cmd  = CMD_FIRE;
    bus.cntr = 0;
    p0 = ecnt + 1;
  endtask

  task automatic run_cntr(int n);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      bus.cntr = k;
    end
  endtask

  task automatic send_cmd(logic [1:0] c, logic [3:0] err, string tag);
    @(negedge clk);
    bus.cmd = c;
    exp_at(ecnt + 1, 4'h0, 4'h0, err, 1'b0, tag);
  endtask

  initial begin
    int p0;
    logic [3:0] m;
    reset_n              = 1'b0;
    bus.cmd              = CMD_FIRE;
    bus.cntr             = 0;
    bus.fireSwitch       = 1'b1;
    bus.phaseDelay       = '0;
    bus.fireAtPhaseDelay = '0;
    bus.chargeTime       = {4{9'd3}};
    bus.chanEnable       = 4'hF;
    bus.pulseCount       = 4'd1;
    bus.pulsePeriod      = 16'd10;
    for (int i = 1; i <= 3; i++)
      exp_at(i, 4'h0, 4'h0, 4'h0, 1'b0, "reset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    bus.cmd = CMD_IDLE;
    @(negedge clk);

    // staggered single pulses, count 1 ignores period<=ct
    bus.phaseDelay  = {16'd15, 16'd10, 16'd5, 16'd0};
    bus.pulsePeriod = 16'd2;
    fire_start(p0);
    for (int k = 0; k <= 22; k++) begin
      m = '0;
      for (int i = 0; i < 4; i++)
        m[i] = (k >= 5*i) && (k <= 5*i + 2);
      exp_at(p0 + k, m,
             {k <= 17, k <= 12, k <= 7, k <= 2},
             4'h0, k >= 19, "stagger");
    end
    run_cntr(22);
    send_cmd(CMD_IDLE, 4'h0, "stagger_idle");

    // three pulses of 4 every 20 starting at 10
    bus.phaseDelay  = {4{16'd10}};
    bus.chargeTime  = {4{9'd4}};
    bus.pulseCount  = 4'd3;
    bus.pulsePeriod = 16'd20;
    fire_start(p0);
    for (int k = 0; k <= 57; k++) begin
      m = ((k >= 10 && k <= 13) || (k >= 30 && k <= 33) ||
           (k >= 50 && k <= 53)) ? 4'hF : 4'h0;
      exp_at(p0 + k, m, (k <= 53) ? 4'hF : 4'h0,
             4'h0, k >= 55, "burst3");
    end
    run_cntr(57);
    send_cmd(CMD_IDLE, 4'h0, "burst3_idle");

    // period equal to charge time: fault, retained on idle, cleared by 11
    bus.phaseDelay  = '0;
    bus.pulseCount  = 4'd2;
    bus.pulsePeriod = 16'd4;
    fire_start(p0);
    for (int k = 0; k <= 3; k++)
      exp_at(p0 + k, 4'h0, 4'h0, 4'hF, k >= 1, "perr");
    run_cntr(3);
    send_cmd(CMD_IDLE, 4'hF, "perr_keep");
    send_cmd(CMD_RESET, 4'h0, "perr_clr11");

    // same fault cleared by the 01 encoding
    fire_start(p0);
    for (int k = 0; k <= 1; k++)
      exp_at(p0 + k, 4'h0, 4'h0, 4'hF, k >= 1, "perr2");
    run_cntr(1);
    send_cmd(2'b01, 4'h0, "perr_clr01");
    send_cmd(CMD_IDLE, 4'h0, "perr_idle");

    // long 20-tick pulse, no timeout in this build
    bus.chargeTime  = {4{9'd20}};
    bus.pulseCount  = 4'd1;
    bus.pulsePeriod = 16'd0;
    fire_start(p0);
    for (int k = 0; k <= 23; k++)
      exp_at(p0 + k, (k <= 19) ? 4'hF : 4'h0,
             (k <= 19) ? 4'hF : 4'h0, 4'h0, k >= 21, "long");
    run_cntr(23);
    send_cmd(CMD_IDLE, 4'h0, "long_idle");

    // abort mid-pulse with cmd 00
    fire_start(p0);
    for (int k = 0; k <= 3; k++)
      exp_at(p0 + k, 4'hF, 4'hF, 4'h0, 1'b0, "abort");
    run_cntr(3);
    send_cmd(CMD_IDLE, 4'h0, "abort_drop");

    // reset mid-pulse, held with cmd still firing
    fire_start(p0);
    for (int k = 0; k <= 3; k++)
      exp_at(p0 + k, 4'hF, 4'hF, 4'h0, 1'b0, "rstmid");
    run_cntr(3);
    @(negedge clk);
    reset_n = 1'b0;
    exp_at(ecnt + 1, 4'h0, 4'h0, 4'h0, 1'b0, "rstmid_drop");
    @(negedge clk);
    bus.cmd = CMD_IDLE;
    exp_at(ecnt + 1, 4'h0, 4'h0, 4'h0, 1'b0, "rstmid_hold");
    @(negedge clk);
    reset_n = 1'b1;
    exp_at(ecnt + 1, 4'h0, 4'h0, 4'h0, 1'b0, "rstmid_rel");

    // alternate delay, ch1 zero charge time, ch3 disabled
    bus.fireSwitch       = 1'b0;
    bus.phaseDelay       = {4{16'd2}};
    bus.fireAtPhaseDelay = {4{16'd7}};
    bus.chargeTime       = {9'd3, 9'd3, 9'd0, 9'd3};
    bus.chanEnable       = 4'b0111;
    bus.pulsePeriod      = 16'd50;
    fire_start(p0);
    for (int k = 0; k <= 13; k++)
      exp_at(p0 + k, (k >= 7 && k <= 9) ? 4'b0101 : 4'h0,
             (k <= 9) ? 4'b0101 : 4'h0, 4'h0, k >= 11, "altsel");
    run_cntr(13);
    send_cmd(CMD_IDLE, 4'h0, "altsel_idle");

    // nothing enabled: burstDone at L+2
    bus.chanEnable = 4'h0;
    fire_start(p0);
    for (int k = 0; k <= 3; k++)
      exp_at(p0 + k, 4'h0, 4'h0, 4'h0, k >= 1, "noen");
    run_cntr(3);
    send_cmd(CMD_IDLE, 4'h0, "noen_idle");

    for (int i = 0; i < 100 && q.size() > 0; i++)
      @(negedge clk);
    while (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      total++;
      $display("FAIL %s edge %0d never checked", x.tag, x.ed);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/tx_burst_array.md
TX_BURST_ARRAY -- requirements
Module: tx_burst_array

Interface
REQ-001 NCH, 8, number of transducer channels (1..64).
REQ-002 PD_W, 16, phase-delay width per channel.
REQ-003 CT_W, 9, charge-time width per channel.
REQ-004 BURST_W, 4, pulse-count width.
REQ-005 SAFE_W, 10, safety-valve counter width.
REQ-006 clk  in  1  sole clock, all logic on rising edge.
REQ-007 reset_n  in  1  reset, synchronous, active-low.
REQ-008 cntr  in  32  shared timebase, monotonic within a burst.
REQ-009 cmd  in  2  00 idle, 10 fire, 11 reset module, 01 treated as 11.
REQ-010 phaseDelay  in  NCH*PD_W  primary per-channel delay; channel i at [i*PD_W +: PD_W].
REQ-011 fireAtPhaseDelay  in  NCH*PD_W  alternate per-channel delay.
REQ-012 fireSwitch  in  1  1 selects phaseDelay, 0 selects fireAtPhaseDelay.
REQ-013 chargeTime  in  NCH*CT_W  per-channel pulse width in cntr ticks.
REQ-014 chanEnable  in  NCH  per-channel enable, sampled at latch.
REQ-015 pulseCount  in  BURST_W  pulses per burst, shared.
REQ-016 pulsePeriod  in  16  start-to-start spacing in cntr ticks, shared.
REQ-017 txOutputState  out  NCH  registered transducer drive.
REQ-018 isActive  out  NCH  channel mid-burst.
REQ-019 errorFlag  out  NCH  sticky per-channel fault.
REQ-020 burstDone  out  1  all enabled channels finished.

Function
REQ-021 Each channel SHALL run FSM IDLE, WAIT, PULSE, DONE, FAULT; all outputs registered.
REQ-022 Latch cycle L = first cycle with cmd==10 and channel in IDLE: SHALL capture selected delay, chargeTime, pulseCount, pulsePeriod; start = zero-extended delay (32-bit).
REQ-023 If chanEnable==0, chargeTime==0 or pulseCount==0: SHALL go DONE at L+1, no pulse, isActive 0.
REQ-024 If pulseCount>1 and pulsePeriod<=chargeTime: SHALL go DONE at L+1, no pulse, errorFlag set.
REQ-025 Otherwise SHALL go WAIT, isActive=1 at L+1; if delay==0, txOutputState=1 at L+1 (state PULSE).
REQ-026 WAIT: when cntr>=start, txOutputState=1 next cycle, state PULSE.
REQ-027 PULSE: when cntr>=start+chargeTime, txOutputState=0 next cycle, remaining decremented; remaining 0 -> DONE, isActive=0; else start+=pulsePeriod, WAIT.
REQ-028 All additions 32-bit unsigned; cntr wrap within a burst is unsupported and undefined.
REQ-029 DONE/FAULT SHALL hold txOutputState=0 until cmd leaves 10; no re-fire without passing through idle/reset.
REQ-030 cmd->00 at any state: txOutputState=0, isActive=0, state IDLE next cycle; errorFlag retained.
REQ-031 cmd->11/01: as REQ-030 and errorFlag cleared.
REQ-032 burstDone=1 one cycle after every channel with latched enable is in DONE or FAULT while cmd==10; 0 otherwise; with no enabled channels, 1 at L+2.

Reset
REQ-033 reset_n==0 at a rising edge SHALL force all channels IDLE, txOutputState=0, isActive=0, errorFlag=0, burstDone=0, counters 0, overriding cmd.
REQ-034 Reset mid-pulse SHALL drop txOutputState on the next edge; no pulse resumes after release until a new latch.

Configuration
REQ-035 Macro TX_SAFETY_VALVE_EN defined: per-channel SAFE_W counter increments each cycle txOutputState==1, clears when low; when bit SAFE_W-1 set, txOutputState=0 next cycle, errorFlag=1, state FAULT, isActive=0.
REQ-036 Macro undefined: no counter, no FAULT entry by timeout; errorFlag driven only by REQ-024.

Structure
REQ-037 Package tx_pkg SHALL hold cmd encodings (CMD_IDLE, CMD_FIRE, CMD_RESET) and channel state enum.
REQ-038 Per-channel logic SHALL be sub-module tx_channel, instantiated NCH times by generate; top holds burstDone reduction only.

Verification
REQ-039 NCH=4, delays 0/5/10/15, ct=3, count=1, cntr 0.. -> ch0 high at L+1 for 3 ticks, chN high from cntr=5N to 5N+3.
REQ-040 count=3, period=20, ct=4, delay=10 -> pulses at cntr 10,30,50 each 4 wide, isActive falls after third, burstDone 1.
REQ-041 period=4, ct=4, count=2 -> no pulse, errorFlag=1; cmd=11 -> errorFlag=0.
REQ-042 cmd 10->00 mid-pulse -> txOutputState 0 next cycle, isActive 0; reset_n low mid-pulse same.
REQ-043 With TX_SAFETY_VALVE_EN, SAFE_W=4, ct=20, cntr advancing each cycle -> output falls after 8 high cycles, errorFlag=1, FAULT; without macro full 20-tick pulse, no error.
REQ-044 fireSwitch=0, fireAtPhaseDelay=7, chanEnable=0101 -> only ch0, ch2 fire at cntr 7; burstDone after both done.
